// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with 3-sample majority voting and error flags
module uart_rx_param #(
    parameter int CLK_DIV   = 2604,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX,
    input  logic                 clr_rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rdy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK
    } state_t;

    localparam logic [15:0] DIV_FULL  = 16'(CLK_DIV);
    localparam logic [15:0] DIV_HALF  = 16'(CLK_DIV / 2);
    localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic [2:0]             maj_q;
    logic [15:0]            cnt_q, cnt_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_ok_q, par_ok_d;
    logic                   stop_err_q, stop_err_d;
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   rdy_q, parity_err_q, frame_err_q, overrun_q;
    logic                   commit, commit_ferr;
    logic                   samp, vote;

    assign samp = (cnt_q == 16'd1);
    assign vote = (maj_q[0] & maj_q[1]) | (maj_q[0] & maj_q[2]) | (maj_q[1] & maj_q[2]);

    // Two-flop synchroniser plus the 3-deep vote window; idle line level is 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            maj_q     <= 3'b111;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
            maj_q     <= {maj_q[1:0], rx_s_q};
        end
    end

    // Next-state and datapath decode; commit is a single-cycle strobe at the last stop sample
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_ok_d    = par_ok_q;
        stop_err_d  = stop_err_q;
        commit      = 1'b0;
        commit_ferr = 1'b0;
        if (state_q != S_IDLE && state_q != S_BRK) begin
            cnt_d = samp ? DIV_FULL : cnt_q - 16'd1;
        end
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d    = S_START;
                    cnt_d      = DIV_HALF;
                    bit_d      = 4'd0;
                    par_ok_d   = 1'b1;
                    stop_err_d = 1'b0;
                end
            end
            S_START: begin
                if (samp) begin
                    state_d = vote ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (samp) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_DATA) begin
                        bit_d   = 4'd0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (samp) begin
                    // Odd parity: total ones including the parity bit must be odd
                    par_ok_d = (PARITY == 1) ? (^shift_q ^ vote) : ~(^shift_q ^ vote);
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                if (samp) begin
                    if (bit_q == LAST_STOP) begin
                        commit      = 1'b1;
                        commit_ferr = stop_err_q | ~vote;
                        state_d     = commit_ferr ? S_BRK : S_IDLE;
                    end else begin
                        stop_err_d = stop_err_q | ~vote;
                        bit_d      = bit_q + 4'd1;
                    end
                end
            end
            S_BRK: begin
                // Hold off until the line idles so a break cannot look like a new start
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state and frame-assembly registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 16'd0;
            bit_q      <= 4'd0;
            shift_q    <= '0;
            par_ok_q   <= 1'b1;
            stop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_ok_q   <= par_ok_d;
            stop_err_q <= stop_err_d;
        end
    end

    // Output word and sticky flags; a commit overrides a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_q    <= '0;
            rdy_q        <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (commit) begin
            rx_data_q    <= shift_q;
            rdy_q        <= 1'b1;
            parity_err_q <= ~par_ok_q;
            frame_err_q  <= commit_ferr;
            overrun_q    <= clr_rdy ? 1'b0 : (overrun_q | rdy_q);
        end else if (clr_rdy) begin
            rdy_q        <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end
    end

    assign rx_data    = rx_data_q;
    assign rdy        = rdy_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for uart_rx_param (8N1 and 8E1 instances)
module tb_uart_rx_param;

    logic       clk;
    logic       rst;
    logic       rx_a, rx_b;
    logic       clr_a, clr_b;
    logic [7:0] rxd_a, rxd_b;
    logic       rdy_a, pe_a, fe_a, ov_a, busy_a;
    logic       rdy_b, pe_b, fe_b, ov_b, busy_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       ov;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    uart_rx_param #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .RX(rx_a), .clr_rdy(clr_a),
        .rx_data(rxd_a), .rdy(rdy_a), .parity_err(pe_a), .frame_err(fe_a),
        .overrun(ov_a), .busy(busy_a)
    );

    uart_rx_param #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .RX(rx_b), .clr_rdy(clr_b),
        .rx_data(rxd_b), .rdy(rdy_b), .parity_err(pe_b), .frame_err(fe_b),
        .overrun(ov_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
    endtask

    // One bit period of 16 clocks; optional single-clock inversion inside the vote window
    task automatic drive_bit(input int sel, input logic b, input bit noise);
        set_rx(sel, b);
        repeat (6) @(negedge clk);
        if (noise) begin
            set_rx(sel, ~b);
            @(negedge clk);
            set_rx(sel, b);
            repeat (9) @(negedge clk);
        end else begin
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input bit use_par,
                              input logic par, input logic stop, input bit noise);
        drive_bit(sel, 1'b0, noise);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i], noise);
        if (use_par) drive_bit(sel, par, noise);
        drive_bit(sel, stop, noise);
    endtask

    task automatic pulse_clr(input int sel);
        if (sel == 0) clr_a = 1'b1;
        else          clr_b = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        clr_b = 1'b0;
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic fe, input logic ov);
        exp_t e;
        e.d = d; e.pe = pe; e.fe = fe; e.ov = ov;
        return e;
    endfunction

    // Monitors: a frame is presented when rdy rises or a new commit changes the held word/flags
    logic [7:0] pd_a, pd_b;
    logic       pr_a, pp_a, pf_a, po_a, pr_b, pp_b, pf_b, po_b;
    initial begin
        pd_a = '0; pr_a = 0; pp_a = 0; pf_a = 0; po_a = 0;
        pd_b = '0; pr_b = 0; pp_b = 0; pf_b = 0; po_b = 0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && rdy_a && (!pr_a || rxd_a != pd_a || pe_a != pp_a || fe_a != pf_a || ov_a != po_a)) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_frame", int'(rxd_a), -1);
            end else begin
                e = q_a.pop_front();
                chk("a_rx_data", int'(rxd_a), int'(e.d));
                chk("a_parity_err", int'(pe_a), int'(e.pe));
                chk("a_frame_err", int'(fe_a), int'(e.fe));
                chk("a_overrun", int'(ov_a), int'(e.ov));
            end
        end
        pd_a = rxd_a; pr_a = rdy_a; pp_a = pe_a; pf_a = fe_a; po_a = ov_a;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && rdy_b && (!pr_b || rxd_b != pd_b || pe_b != pp_b || fe_b != pf_b || ov_b != po_b)) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_frame", int'(rxd_b), -1);
            end else begin
                e = q_b.pop_front();
                chk("b_rx_data", int'(rxd_b), int'(e.d));
                chk("b_parity_err", int'(pe_b), int'(e.pe));
                chk("b_frame_err", int'(fe_b), int'(e.fe));
                chk("b_overrun", int'(ov_b), int'(e.ov));
            end
        end
        pd_b = rxd_b; pr_b = rdy_b; pp_b = pe_b; pf_b = fe_b; po_b = ov_b;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        rx_a = 1'b1; rx_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0; rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rdy", int'(rdy_a), 0);
        chk("reset_rx_data", int'(rxd_a), 0);
        chk("reset_flags", int'({pe_a, fe_a, ov_a}), 0);
        chk("reset_busy", int'({busy_a, busy_b}), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 basic frame and clear
        q_a.push_back(mk(8'hA5, 0, 0, 0));
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1, 0);
        repeat (4) @(negedge clk);
        chk("t1_rdy_set", int'(rdy_a), 1);
        clr_a = 1'b1;
        @(negedge clk);
        chk("t1_rdy_cleared", int'(rdy_a), 0);
        clr_a = 1'b0;

        // Start glitch rejected
        rx_a = 1'b0;
        repeat (5) @(negedge clk);
        rx_a = 1'b1;
        repeat (20) @(negedge clk);
        chk("t2_busy", int'(busy_a), 0);
        chk("t2_rdy", int'(rdy_a), 0);
        chk("t2_flags", int'({pe_a, fe_a, ov_a}), 0);

        // Even parity: bad parity bit then good parity bit
        q_b.push_back(mk(8'h07, 1, 0, 0));
        send_frame(1, 8'h07, 1, 1'b0, 1'b1, 0);
        repeat (4) @(negedge clk);
        pulse_clr(1);
        q_b.push_back(mk(8'h07, 0, 0, 0));
        send_frame(1, 8'h07, 1, 1'b1, 1'b1, 0);
        repeat (4) @(negedge clk);
        pulse_clr(1);

        // Framing error followed by a break, then recovery
        q_a.push_back(mk(8'h81, 0, 1, 0));
        send_frame(0, 8'h81, 0, 1'b0, 1'b0, 0);
        repeat (100) @(negedge clk);
        chk("t4_busy_in_brk", int'(busy_a), 1);
        chk("t4_frame_err", int'(fe_a), 1);
        rx_a = 1'b1;
        repeat (20) @(negedge clk);
        chk("t4_busy_after_brk", int'(busy_a), 0);
        pulse_clr(0);
        q_a.push_back(mk(8'h3C, 0, 0, 0));
        send_frame(0, 8'h3C, 0, 1'b0, 1'b1, 0);
        repeat (4) @(negedge clk);
        pulse_clr(0);

        // Back-to-back frames without clearing: overrun
        q_a.push_back(mk(8'h11, 0, 0, 0));
        q_a.push_back(mk(8'h22, 0, 0, 1));
        send_frame(0, 8'h11, 0, 1'b0, 1'b1, 0);
        send_frame(0, 8'h22, 0, 1'b0, 1'b1, 0);
        repeat (4) @(negedge clk);
        pulse_clr(0);
        repeat (4) @(negedge clk);

        // Back-to-back with clr_rdy on the commit cycle of the second frame
        q_a.push_back(mk(8'h33, 0, 0, 0));
        q_a.push_back(mk(8'h44, 0, 0, 0));
        send_frame(0, 8'h33, 0, 1'b0, 1'b1, 0);
        fork
            send_frame(0, 8'h44, 0, 1'b0, 1'b1, 0);
            begin
                repeat (154) @(negedge clk);
                clr_a = 1'b1;
                @(negedge clk);
                clr_a = 1'b0;
            end
        join
        chk("t5_rdy_after_clr_commit", int'(rdy_a), 1);
        chk("t5_overrun_after_clr_commit", int'(ov_a), 0);
        pulse_clr(0);

        // Noise pulse inside every bit's vote window
        q_a.push_back(mk(8'h5A, 0, 0, 0));
        send_frame(0, 8'h5A, 0, 1'b0, 1'b1, 1);
        repeat (4) @(negedge clk);

        // Reset in the middle of a frame
        rx_a = 1'b0;
        repeat (40) @(negedge clk);
        chk("t6_busy_before_rst", int'(busy_a), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_rdy", int'(rdy_a), 0);
        chk("t6_rst_rx_data", int'(rxd_a), 0);
        chk("t6_rst_flags", int'({pe_a, fe_a, ov_a}), 0);
        chk("t6_rst_busy", int'(busy_a), 0);
        rx_a = 1'b1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_idle_after_rst", int'({busy_a, rdy_a}), 0);

        chk("scoreboard_a_empty", q_a.size(), 0);
        chk("scoreboard_b_empty", q_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
